// File: rtl/csr_sched.sv
// In-order two-entry CSR op scheduler: holds ops from rename, issues the head
// once it reaches the ROB head, and waits for the CSR unit response before popping.
module csr_sched #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rename_csr_valid,
  input  logic [4:0]  rename_op,
  input  logic [7:0]  rename_robid,
  input  logic [5:0]  rename_rd,
  input  logic [31:0] rename_op1,
  input  logic [31:0] rename_op2,
  output logic        csr_sched_stall,
  input  logic [7:0]  rob_head_robid,
  input  logic        rob_flush,
  output logic        sched_csr_write,
  output logic [4:0]  sched_op,
  output logic [7:0]  sched_robid,
  output logic [5:0]  sched_rd,
  output logic [31:0] sched_op1,
  output logic [31:0] sched_op2,
  input  logic        csr_valid,
  input  logic [7:0]  csr_robid
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  count_q, count_d;
  logic        head_q, head_d;
  logic        tail_q, tail_d;

  logic [4:0]  op_q    [DEPTH];
  logic [7:0]  robid_q [DEPTH];
  logic [5:0]  rd_q    [DEPTH];
  logic [31:0] op1_q   [DEPTH];
  logic [31:0] op2_q   [DEPTH];

  logic full, enq, pop, head_match;

  assign full       = (count_q == 2'd2);
  assign enq        = rename_csr_valid && !full && !rob_flush;
  assign head_match = (robid_q[head_q] == rob_head_robid);
  assign pop        = (state_q == RESP) && csr_valid && (csr_robid == robid_q[head_q]);

  assign csr_sched_stall = full && !rst;
  assign sched_csr_write = (state_q == ISSUE) && !rob_flush && !rst;

  assign sched_op    = op_q[head_q];
  assign sched_robid = robid_q[head_q];
  assign sched_rd    = rd_q[head_q];
  assign sched_op1   = op1_q[head_q];
  assign sched_op2   = op2_q[head_q];

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    head_d  = head_q;
    tail_d  = tail_q;

    if (enq) tail_d = ~tail_q;
    if (pop) head_d = ~head_q;

    case ({enq, pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

    case (state_q)
      IDLE:    if (enq) state_d = WAIT;
      WAIT:    if (head_match) state_d = ISSUE;
      ISSUE:   state_d = RESP;
      RESP:    if (pop) state_d = (count_d != 2'd0) ? WAIT : IDLE;
      default: state_d = IDLE;
    endcase

    // Flush wins over any same-cycle enqueue, match or response.
    if (rob_flush) begin
      state_d = IDLE;
      count_d = '0;
      head_d  = '0;
      tail_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      count_q <= '0;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      op_q[tail_q]    <= rename_op;
      robid_q[tail_q] <= rename_robid;
      rd_q[tail_q]    <= rename_rd;
      op1_q[tail_q]   <= rename_op1;
      op2_q[tail_q]   <= rename_op2;
    end
  end

endmodule

// File: doc/csr_sched.md
CSR_SCHED -- requirements
Module: csr_sched

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning the number of queue entries; only the value 2 is supported.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port rename_csr_valid, input, 1 bit: rename presents a CSR op this cycle.
REQ-005 SHALL have ports rename_op[4:0], rename_robid[7:0], rename_rd[5:0], rename_op1[31:0] and rename_op2[31:0], all inputs: the CSR op payload.
REQ-006 SHALL have port csr_sched_stall, output, 1 bit: queue full, so rename must hold.
REQ-007 SHALL have port rob_head_robid, input, 8 bits: ROB id of the oldest uncommitted instruction.
REQ-008 SHALL have port rob_flush, input, 1 bit: pipeline flush.
REQ-009 SHALL have port sched_csr_write, output, 1 bit: one-cycle issue strobe to the CSR unit.
REQ-010 SHALL have ports sched_op[4:0], sched_robid[7:0], sched_rd[5:0], sched_op1[31:0] and sched_op2[31:0], all outputs: the payload of the head entry.
REQ-011 SHALL have ports csr_valid (input, 1 bit) and csr_robid (input, 8 bits): the CSR unit's writeback response.

Function
REQ-012 SHALL hold up to 2 CSR ops in an in-order FIFO with a 1-bit head pointer, a 1-bit tail pointer and a 2-bit count.
REQ-013 SHALL drive csr_sched_stall = (count == 2), decoded from registered state only.
REQ-014 SHALL enqueue when rename_csr_valid && !csr_sched_stall && !rob_flush; the entry is visible from the next cycle.
REQ-015 SHALL compute stall from the current count, so that when full, a same-cycle pop does not admit an enqueue.
REQ-016 SHALL implement states IDLE (count 0), WAIT (head waiting to reach ROB head), ISSUE (strobe cycle) and RESP (awaiting CSR response).
REQ-017 SHALL go IDLE->WAIT the cycle after an enqueue into an empty queue.
REQ-018 SHALL go WAIT->ISSUE when head robid == rob_head_robid; a match in cycle N SHALL give the strobe in cycle N+1.
REQ-019 SHALL drive sched_csr_write = (state == ISSUE) && !rob_flush, asserted for exactly one cycle per op.
REQ-020 SHALL go ISSUE->RESP unconditionally unless flushed.
REQ-021 SHALL, in RESP, treat csr_valid && csr_robid == head robid as the response; it SHALL then pop the head and go to WAIT if count after the pop is nonzero, else IDLE.
REQ-022 SHALL ignore csr_valid whose robid mismatches, or that arrives in any state other than RESP.
REQ-023 SHALL present the head entry on the sched_* payload at all times; the payload is don't-care when count is 0.
REQ-024 SHALL never issue more than one op before its response; at most one op is outstanding.
REQ-025 SHALL, on rob_flush, clear count and both pointers and go to IDLE next cycle from any state; flush beats a same-cycle enqueue, match or response.
REQ-026 SHALL ignore a response for an op flushed while in RESP, since state is then IDLE or robid mismatches.
REQ-027 SHALL compare robid on all 8 bits with no age arithmetic; wrap-around of ROB ids needs no special handling.
REQ-028 SHALL process a same-cycle enqueue and pop with count unchanged.

Reset
REQ-029 SHALL, on rst high at a clock edge, set state IDLE, count 0, head 0 and tail 0.
REQ-030 SHALL, during and after reset, drive csr_sched_stall 0 and sched_csr_write 0; queue payload registers need not be reset.
REQ-031 SHALL let rst abort any in-flight op mid-operation with the same effect as flush, and rst SHALL override all other inputs.

Verification
REQ-032 SHALL cover basic issue: enqueue robid 0x12, then rob_head_robid=0x12 in cycle N -> sched_csr_write=1 only in cycle N+1 with sched_robid=0x12; csr_valid with robid 0x12 -> state IDLE, stall 0.
REQ-033 SHALL cover full queue: enqueue 0x05 and 0x06 with no response -> stall=1; a third valid op is not accepted; after response 0x05, 0x06 issues once rob_head_robid=0x06.
REQ-034 SHALL cover flush in RESP: issue 0x20, assert flush, then csr_valid with robid 0x20 -> ignored, count 0, no further strobe.
REQ-035 SHALL cover flush coincident with ISSUE: sched_csr_write stays 0 that cycle and state is IDLE next cycle.
REQ-036 SHALL cover wrong-robid response: in RESP for 0xFF, csr_valid with robid 0x00 -> no pop; the later csr_valid with robid 0xFF pops.
REQ-037 SHALL cover mid-operation reset: rst in WAIT with count 2 -> next cycle stall=0, strobe 0, and a new enqueue works normally.
